synaptic_weight_mem: RTL

SYNAPTIC_WEIGHT_MEM -- requirements
Module: synaptic_weight_mem

---
 rtl/synaptic_mem_pkg.sv | 26 ++
 rtl/weight_sat_add.sv | 25 ++
 rtl/synaptic_weight_mem.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/synaptic_mem_pkg.sv
// Shared types and helpers for the synaptic weight memory.
// Holds the controller state encoding and the clamping function used by the update adder.
package synaptic_mem_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } mem_state_t;

    // Clamps a signed value to the range of a width-bit two's-complement number.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                     input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/weight_sat_add.sv
// Saturating weight adder: old weight plus sign-extended delta, clamped to the weight range.
// The sum is formed one bit wider than the weight so overflow is never lost before clamping.
module weight_sat_add
    import synaptic_mem_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 8,
    parameter int DELTA_WIDTH  = 8
) (
    input  logic signed [WEIGHT_WIDTH-1:0] old_weight,
    input  logic signed [DELTA_WIDTH-1:0]  delta,
    output logic signed [WEIGHT_WIDTH-1:0] sum,
    output logic                           sat
);

    logic signed [WEIGHT_WIDTH:0] wide_sum;
    logic signed [63:0]           clamped;

    always_comb begin
        wide_sum = (WEIGHT_WIDTH + 1)'(old_weight) + (WEIGHT_WIDTH + 1)'(delta);
        clamped  = sat_clamp(64'(wide_sum), WEIGHT_WIDTH);
        sum      = clamped[WEIGHT_WIDTH-1:0];
        sat      = (clamped != 64'(wide_sum));
    end

endmodule

// File: rtl/synaptic_weight_mem.sv
// Synaptic weight store: host loads, pipelined spike lookups and saturating learning updates.
// A clear sweep zeroes every word after reset or on request before normal operation resumes.
module synaptic_weight_mem
    import synaptic_mem_pkg::*;
#(
    parameter  int NUM_ENTRIES  = 256,
    parameter  int WEIGHT_WIDTH = 8,
    parameter  int DELTA_WIDTH  = 8,
    localparam int AW           = $clog2(NUM_ENTRIES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           host_we,
    input  logic [AW-1:0]                  host_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] host_wdata,
    input  logic                           rd_en,
    input  logic [AW-1:0]                  rd_addr,
    output logic                           rd_valid,
    output logic signed [WEIGHT_WIDTH-1:0] rd_data,
    input  logic                           upd_en,
    input  logic [AW-1:0]                  upd_addr,
    input  logic signed [DELTA_WIDTH-1:0]  upd_delta,
    output logic                           upd_ready,
    output logic                           sat_pulse,
    output logic                           busy,
    input  logic                           clear_req
);

    logic signed [WEIGHT_WIDTH-1:0] mem [NUM_ENTRIES];

    mem_state_t                     state;
    mem_state_t                     state_next;
    logic [AW-1:0]                  clr_cnt;
    logic                           clr_last;

    logic                           upd_accept;
    logic                           run_read;
    logic signed [WEIGHT_WIDTH-1:0] s1_old;

    logic                           s2_valid;
    logic [AW-1:0]                  s2_addr;
    logic signed [WEIGHT_WIDTH-1:0] s2_old;
    logic signed [DELTA_WIDTH-1:0]  s2_delta;
    logic signed [WEIGHT_WIDTH-1:0] s2_sum;
    logic                           s2_sat;
    logic                           s2_write;

    weight_sat_add #(
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .DELTA_WIDTH (DELTA_WIDTH)
    ) u_sat_add (
        .old_weight(s2_old),
        .delta     (s2_delta),
        .sum       (s2_sum),
        .sat       (s2_sat)
    );

    assign clr_last = (clr_cnt == AW'(NUM_ENTRIES - 1));

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        upd_ready  = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr_last) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                upd_ready = !host_we;
                if (clear_req) begin
                    state_next = CLEAR;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // A host write to the same address wins over the stage-2 update; an accepted update can
    // never coincide with a host write, so stage 1 only needs to forward the stage-2 result.
    always_comb begin
        upd_accept = upd_en && upd_ready;
        run_read   = (state == RUN) && rd_en && !clear_req;
        s2_write   = s2_valid && !(host_we && (host_addr == s2_addr));
        if (s2_write && (s2_addr == upd_addr)) begin
            s1_old = s2_sum;
        end else begin
            s1_old = mem[upd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR && !clr_last) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    // Entering the sweep drops anything accepted in the same cycle along with its lookup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_addr   <= '0;
            s2_old    <= '0;
            s2_delta  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            sat_pulse <= 1'b0;
        end else begin
            s2_valid  <= upd_accept && !clear_req;
            sat_pulse <= s2_write && s2_sat;
            rd_valid  <= run_read;
            if (upd_accept) begin
                s2_addr  <= upd_addr;
                s2_old   <= s1_old;
                s2_delta <= upd_delta;
            end
            if (run_read) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (s2_write) begin
                mem[s2_addr] <= s2_sum;
            end
            if (host_we) begin
                mem[host_addr] <= host_wdata;
            end
        end
    end

endmodule
